router_pkt_sink: RTL

- Receive-side endpoint for one destination port of the 1x3 router.
- Pulls packets out of a router output FIFO using the vld_out/read_enb handshake.
- Reassembles each packet (header, payload, parity), checks its parity and destination address, and reports per-packet status and running counters.
- Instantiated once per output port in integration benches and in the loopback top. It is the consuming end of the packet stream the source side produces.

---
 rtl/router_pkt_sink.sv | 122 ++++++++++++
 1 files changed

// File: rtl/router_pkt_sink.sv
// router_pkt_sink: drains one router output FIFO, reassembles packets, checks parity/address
module router_pkt_sink #(
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         READ_DELAY = 2,
    parameter int         TIMEOUT    = 32,
    parameter int         CNT_W      = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_vld_out,
    input  logic [7:0]       i_data_out,
    output logic             o_read_enb,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_data_valid,
    output logic             o_pkt_done,
    output logic [5:0]       o_pkt_len,
    output logic [1:0]       o_pkt_addr,
    output logic             o_parity_err,
    output logic             o_addr_err,
    output logic             o_pkt_abort,
    output logic [CNT_W-1:0] o_pkt_count,
    output logic [CNT_W-1:0] o_err_count
);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RX, DONE} state_t;
    state_t           r_state, w_next;
    logic [4:0]       r_dly_cnt;
    logic [6:0]       r_pops_issued, r_idx, w_pops_total;
    logic [IW-1:0]    r_idle_cnt;
    logic [7:0]       r_xor, r_rx_data;
    logic             r_pop_d, r_rx_data_valid, r_parity_err, r_addr_err, r_pkt_abort;
    logic [5:0]       r_pkt_len;
    logic [1:0]       r_pkt_addr;
    logic [CNT_W-1:0] r_pkt_count, r_err_count;
    logic             w_pop, w_last, w_timeout, w_perr, w_aerr;

    // Until the header is sampled the length is unknown, so allow the maximum;
    // at most two pops go out before that, and every packet has at least two bytes.
    assign w_pops_total = (r_idx == 7'd0) ? 7'd65 : 7'(r_pkt_len) + 7'd2;
    assign w_pop        = !i_reset && r_state == RX && i_vld_out && r_pops_issued < w_pops_total;
    assign w_last       = r_pop_d && r_idx != 7'd0 && r_idx == 7'(r_pkt_len) + 7'd1;
    assign w_perr       = i_data_out != r_xor;
    assign w_aerr       = r_pkt_addr != PORT_ID;
    assign w_timeout    = r_state == RX && !w_pop && !w_last && r_idle_cnt == IW'(TIMEOUT - 1);

    assign o_read_enb      = w_pop;
    assign o_rx_data       = r_rx_data;
    assign o_rx_data_valid = r_rx_data_valid;
    assign o_pkt_done      = r_state == DONE;
    assign o_pkt_len       = r_pkt_len;
    assign o_pkt_addr      = r_pkt_addr;
    assign o_parity_err    = r_parity_err;
    assign o_addr_err      = r_addr_err;
    assign o_pkt_abort     = r_pkt_abort;
    assign o_pkt_count     = r_pkt_count;
    assign o_err_count     = r_err_count;

    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (i_enable && i_vld_out) ? ((READ_DELAY == 0) ? RX : WAIT) : IDLE;
            WAIT:    w_next = !i_vld_out ? IDLE : (r_dly_cnt <= 5'd1) ? RX : WAIT;
            RX:      w_next = w_last ? DONE : w_timeout ? IDLE : RX;
            default: w_next = IDLE;
        endcase
    end

    // state register; reset abandons any partial packet
    always_ff @(posedge i_clock) r_state <= i_reset ? IDLE : w_next;

    // byte capture, running parity, per-packet status and saturating counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pop_d         <= 1'b0;
            r_rx_data       <= '0;
            r_rx_data_valid <= 1'b0;
            r_pkt_abort     <= 1'b0;
            r_dly_cnt       <= '0;
            r_pops_issued   <= '0;
            r_idx           <= '0;
            r_idle_cnt      <= '0;
            r_xor           <= '0;
            r_pkt_len       <= '0;
            r_pkt_addr      <= '0;
            r_parity_err    <= 1'b0;
            r_addr_err      <= 1'b0;
            r_pkt_count     <= '0;
            r_err_count     <= '0;
        end else begin
            r_pop_d         <= w_pop;
            r_rx_data_valid <= r_pop_d;
            r_pkt_abort     <= w_timeout;
            r_dly_cnt       <= (r_state == WAIT) ? r_dly_cnt - 5'd1 : 5'(READ_DELAY);
            if (r_pop_d) r_rx_data <= i_data_out;
            if (r_state != RX) begin
                r_pops_issued <= '0;
                r_idx         <= '0;
                r_idle_cnt    <= '0;
                r_xor         <= '0;
            end else begin
                if (w_pop) r_pops_issued <= r_pops_issued + 7'd1;
                r_idle_cnt <= w_pop ? '0 : r_idle_cnt + IW'(1);
                if (r_pop_d) begin
                    r_idx <= r_idx + 7'd1;
                    r_xor <= r_xor ^ i_data_out;
                end
                if (r_pop_d && r_idx == 7'd0) begin
                    r_pkt_len  <= i_data_out[7:2];
                    r_pkt_addr <= i_data_out[1:0];
                end
                if (w_last) begin
                    r_parity_err <= w_perr;
                    r_addr_err   <= w_aerr;
                    if (~&r_pkt_count) r_pkt_count <= r_pkt_count + CNT_W'(1);
                    if ((w_perr || w_aerr) && ~&r_err_count) r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end
endmodule
